// File: rtl/ext_shift_pipe.sv
// Two-stage immediate extender and shifter with a valid/ready handshake on both sides.
// Stage 1 captures the extended word; stage 2 applies the mode's shift and holds the result.
module ext_shift_pipe #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [2:0]         in_mode,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_err
);

    typedef enum logic [2:0] {
        MODE_SEXT   = 3'b000,
        MODE_ZEXT   = 3'b001,
        MODE_BRANCH = 3'b010,
        MODE_UPPER  = 3'b011,
        MODE_SLL    = 3'b100,
        MODE_SRL    = 3'b101,
        MODE_SRA    = 3'b110,
        MODE_ERR    = 3'b111
    } mode_e;

    localparam int UPPER_SHIFT = OUT_W - IN_W;

    logic               s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]   s1_word_q, s1_word_d;
    mode_e              s1_mode_q, s1_mode_d;
    logic [SHAMT_W-1:0] s1_shamt_q, s1_shamt_d;

    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;

    logic               s2_load;
    logic               s1_load;
    logic               accept;
    mode_e              in_mode_e;
    logic [OUT_W-1:0]   ext_word;
    logic [OUT_W-1:0]   shifted;

    assign in_mode_e = mode_e'(in_mode);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        s2_load     = !out_valid_q || out_ready;
        s1_load     = !s1_valid_q || s2_load;
        in_ready    = !reset && !flush && s1_load;
        accept      = in_valid && in_ready;

        if (in_mode_e == MODE_SEXT || in_mode_e == MODE_BRANCH || in_mode_e == MODE_SRA) begin
            ext_word = {{UPPER_SHIFT{in_data[IN_W-1]}}, in_data};
        end else begin
            ext_word = {{UPPER_SHIFT{1'b0}}, in_data};
        end

        // Native shifts already yield 0 (logical) or sign fill (arithmetic) once shamt >= OUT_W.
        shifted = '0;
        case (s1_mode_q)
            MODE_SEXT, MODE_ZEXT: shifted = s1_word_q;
            MODE_BRANCH:          shifted = s1_word_q << 2;
            MODE_UPPER:           shifted = s1_word_q << UPPER_SHIFT;
            MODE_SLL:             shifted = s1_word_q << s1_shamt_q;
            MODE_SRL:             shifted = s1_word_q >> s1_shamt_q;
            MODE_SRA:             shifted = $unsigned($signed(s1_word_q) >>> s1_shamt_q);
            default:              shifted = '0;
        endcase

        s1_valid_d  = s1_valid_q;
        s1_word_d   = s1_word_q;
        s1_mode_d   = s1_mode_q;
        s1_shamt_d  = s1_shamt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        if (s1_load) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_word_d  = ext_word;
            s1_mode_d  = in_mode_e;
            s1_shamt_d = in_shamt;
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = shifted;
                out_err_d  = (s1_mode_q == MODE_ERR);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (flush) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    // NOTE: stage-1 payload is never reset; it is only observed while s1_valid_q is set.
    always_ff @(posedge clk) begin
        s1_word_q  <= s1_word_d;
        s1_mode_q  <= s1_mode_d;
        s1_shamt_q <= s1_shamt_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ext_shift_pipe.sv
// Self-checking bench for ext_shift_pipe: a queue-based transaction model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_ext_shift_pipe;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 32;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic [2:0]         in_mode;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_err;

    always #5 clk = ~clk;

    ext_shift_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from the mode rules using plain signed/unsigned integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] d,
                                          input logic [4:0] s);
        longint sx, zx, p, r;
        zx = longint'(d);
        sx = d[15] ? zx - 65536 : zx;
        p  = 1;
        for (int i = 0; i < int'(s); i++) p = p * 2;
        case (m)
            3'd0:    r = sx;
            3'd1:    r = zx;
            3'd2:    r = sx * 4;
            3'd3:    r = zx * 65536;
            3'd4:    r = zx * p;
            3'd5:    r = zx / p;
            3'd6:    r = (sx >= 0) ? sx / p : -((-sx - 1) / p) - 1;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   edge_n   = 0;
    int   last_pop = 0;
    bit   started  = 0;
    bit   zero_chk = 0;

    // Head is visible one edge after acceptance, and not before its predecessor left.
    function automatic bit m_valid();
        if (q.size() == 0) return 1'b0;
        return (edge_n >= q[0].acc + 1) && (edge_n >= last_pop);
    endfunction

    function automatic bit m_in_ready();
        return !reset && !flush && (q.size() < 2 || out_ready);
    endfunction

    always @(posedge clk) begin : model_p
        bit v, r;
        v = m_valid();
        r = m_in_ready();
        edge_n++;
        if (reset || flush) begin
            q.delete();
            if (reset) begin
                started  = 1;
                zero_chk = 1;
            end
        end else begin
            if (v && out_ready) begin
                void'(q.pop_front());
                last_pop = edge_n;
            end
            if (in_valid && r)
                q.push_back('{data: model(in_mode, in_data, in_shamt),
                              err: (in_mode == 3'b111), acc: edge_n});
        end
    end

    always @(negedge clk) begin : compare_p
        if (started) begin
            check("in_ready", in_ready, m_in_ready());
            check("out_valid", out_valid, m_valid());
            if (m_valid()) begin
                check("out_data", out_data, q[0].data);
                check("out_err", out_err, q[0].err);
                zero_chk = 0;
            end else if (zero_chk) begin
                check("reset_data", out_data, 32'h0);
                check("reset_err", out_err, 32'h0);
            end
        end
    end

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vv[3];

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d,
                         input logic [4:0] s);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
        in_shamt = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic e);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 32'h1);
        check({name, "_data"}, out_data, d);
        check({name, "_err"}, out_err, e);
        #1;
    endtask

    // Offers vv[0..2] on consecutive cycles and expects three gap-free results.
    task automatic burst(input string name);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, vv[i].mode, vv[i].data, vv[i].shamt);
            else       drive(1'b0, 3'd0, 16'h0, 5'd0);
            if (i >= 2) lit($sformatf("%s_%0d", name, i - 2), vv[i-2].exp, vv[i-2].err);
            tick();
        end
    endtask

    vec_t tbl[8];

    initial begin
        int  idx;
        bit  acc;
        bit  pat[5];

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        tick();
        tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 32'h0);
        check("rst_out_valid", out_valid, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_err", out_err, 32'h0);
        #1;
        reset = 1'b0;
        tick();

        // Single sign-extend: visible exactly two cycles after being presented.
        drive(1'b1, 3'b000, 16'h8004, 5'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        @(negedge clk);
        check("sext_early", out_valid, 32'h0);
        #1;
        tick();
        lit("sext", 32'hFFFF8004, 1'b0);
        tick();

        vv[0] = '{3'b001, 16'h8004, 5'd0, 32'h00008004, 1'b0};
        vv[1] = '{3'b010, 16'hFFFF, 5'd0, 32'hFFFFFFFC, 1'b0};
        vv[2] = '{3'b011, 16'h1234, 5'd0, 32'h12340000, 1'b0};
        burst("b2b");

        vv[0] = '{3'b110, 16'h8000, 5'd4,  32'hFFFFF800, 1'b0};
        vv[1] = '{3'b101, 16'h8000, 5'd4,  32'h00000800, 1'b0};
        vv[2] = '{3'b100, 16'h0001, 5'd31, 32'h80000000, 1'b0};
        burst("shift");

        vv[0] = '{3'b110, 16'h8000, 5'd31, 32'hFFFFFFFF, 1'b0};
        vv[1] = '{3'b101, 16'h8000, 5'd0,  32'h00008000, 1'b0};
        vv[2] = '{3'b100, 16'hFFFF, 5'd16, 32'hFFFF0000, 1'b0};
        burst("edge");

        vv[0] = '{3'b001, 16'h0005, 5'd0, 32'h00000005, 1'b0};
        vv[1] = '{3'b111, 16'h1234, 5'd7, 32'h00000000, 1'b1};
        vv[2] = '{3'b001, 16'h0007, 5'd0, 32'h00000007, 1'b0};
        burst("err");

        // Backpressure: three requests offered against a stalled sink.
        vv[0] = '{3'b001, 16'h00AA, 5'd0, 32'h000000AA, 1'b0};
        vv[1] = '{3'b000, 16'hFF00, 5'd0, 32'hFFFFFF00, 1'b0};
        vv[2] = '{3'b011, 16'h0001, 5'd0, 32'h00010000, 1'b0};
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, vv[idx].mode, vv[idx].data, vv[idx].shamt);
            @(negedge clk);
            acc = in_ready;
            if (c >= 2) check("bp_hold", out_data, vv[0].exp);
            #1;
            tick();
            if (acc && idx < 2) idx++;
            else if (acc) idx = 3;
        end
        check("bp_accepted", idx, 32'd2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 32'h0);
        check("bp_first", out_data, vv[0].exp);
        #1;
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        out_ready = 1'b1;
        tick();
        lit("bp_second", vv[1].exp, 1'b0);
        tick();
        @(negedge clk);
        check("bp_drained", out_valid, 32'h0);
        #1;

        // Flush with both stages occupied.
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 16'h1111, 5'd0);
        tick();
        drive(1'b1, 3'b001, 16'h2222, 5'd0);
        tick();
        drive(1'b1, 3'b001, 16'h3333, 5'd0);
        flush = 1'b1;
        @(negedge clk);
        check("fl_in_ready", in_ready, 32'h0);
        check("fl_full", out_valid, 32'h1);
        #1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fl_empty", out_valid, 32'h0);
            #1;
            tick();
        end
        drive(1'b1, 3'b000, 16'h4444, 5'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        @(negedge clk);
        check("fl_lat", out_valid, 32'h0);
        #1;
        tick();
        lit("fl_after", 32'h00004444, 1'b0);
        tick();

        // Reset in mid-stream with an error result on the output.
        drive(1'b1, 3'b111, 16'h0000, 5'd0);
        tick();
        drive(1'b1, 3'b001, 16'h5555, 5'd0);
        tick();
        @(negedge clk);
        check("rs_err_before", out_err, 32'h1);
        #1;
        drive(1'b1, 3'b001, 16'h6666, 5'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rs_in_ready", in_ready, 32'h0);
        #1;
        tick();
        @(negedge clk);
        check("rs_valid", out_valid, 32'h0);
        check("rs_data", out_data, 32'h0);
        check("rs_err", out_err, 32'h0);
        #1;
        reset = 1'b0;
        drive(1'b1, 3'b001, 16'h7777, 5'd0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        tick();
        lit("rs_first", 32'h00007777, 1'b0);
        tick();

        // Flush and reset together behave as reset.
        drive(1'b1, 3'b000, 16'hF00F, 5'd0);
        tick();
        drive(1'b1, 3'b000, 16'h0FF0, 5'd0);
        tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        @(negedge clk);
        check("rf_valid", out_valid, 32'h0);
        check("rf_data", out_data, 32'h0);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        tick();

        // Mixed table under an irregular sink pattern; the model checks every cycle.
        tbl[0] = '{3'd0, 16'h7FFF, 5'd0,  32'h0, 1'b0};
        tbl[1] = '{3'd1, 16'hFFFF, 5'd0,  32'h0, 1'b0};
        tbl[2] = '{3'd2, 16'h8000, 5'd0,  32'h0, 1'b0};
        tbl[3] = '{3'd3, 16'hABCD, 5'd0,  32'h0, 1'b0};
        tbl[4] = '{3'd4, 16'h00F0, 5'd8,  32'h0, 1'b0};
        tbl[5] = '{3'd5, 16'hF000, 5'd12, 32'h0, 1'b0};
        tbl[6] = '{3'd6, 16'hF000, 5'd12, 32'h0, 1'b0};
        tbl[7] = '{3'd7, 16'h1111, 5'd3,  32'h0, 1'b0};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = pat[c % 5];
            if (idx < 8) drive(1'b1, tbl[idx].mode, tbl[idx].data, tbl[idx].shamt);
            else         drive(1'b0, 3'd0, 16'h0, 5'd0);
            @(negedge clk);
            acc = in_valid && in_ready;
            #1;
            tick();
            if (acc) idx++;
        end
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 5'd0);
        tick();
        tick();
        tick();
        check("tbl_all_sent", idx, 32'd8);
        check("tbl_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
